// File: rtl/pio_in_pkg.sv
// pio_in_pkg
// Shared constants for the edge-capturing parallel input port:
//   - Avalon-MM word addresses of the register map
//   - per-channel capture mode encoding (2 bits per channel in MODE)
//   - legal parameter ranges for the channel count and synchroniser depth
//   - edge_event(): decides whether a channel raises a capture event this cycle
package pio_in_pkg;

  localparam int WIDTH_MIN       = 1;
  localparam int WIDTH_MAX       = 16;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_MODE    = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_FILTER  = 3'd4;
  localparam logic [2:0] ADDR_RAW     = 3'd5;

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_ANY   = 2'b10,
    MODE_LEVEL = 2'b11
  } edge_mode_e;

  // Level mode fires on every cycle the filtered value is high; the three
  // edge modes compare the filtered value with its previous-cycle copy.
  function automatic logic edge_event(input edge_mode_e mode,
                                      input logic       cur,
                                      input logic       prev);
    logic ev;
    ev = 1'b0;
    case (mode)
      MODE_RISE:  ev = cur & ~prev;
      MODE_FALL:  ev = ~cur & prev;
      MODE_ANY:   ev = cur ^ prev;
      MODE_LEVEL: ev = cur;
      default:    ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/pio_in_filter.sv
// pio_in_filter
// One input channel: a SYNC_STAGES-deep synchroniser followed by a
// debounce filter. A non-zero filter value N requires the synchronised bit
// to disagree with the filtered bit for N consecutive cycles before the
// filtered bit follows it. With N = 0 the filtered bit is the synchronised
// bit directly.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   in_bit      - raw asynchronous input
//   filter      - shared debounce length (0 = no filtering)
//   clear_cnt   - pulse that restarts the debounce count
//   synced      - synchronised, unfiltered value
//   filtered    - debounced value
module pio_in_filter
  import pio_in_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic [CNT_W-1:0] filter,
  input  logic             clear_cnt,
  output logic             synced,
  output logic             filtered
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;

  assign synced   = sync_q[SYNC_STAGES-1];
  // filt_q keeps tracking the synchronised bit while filtering is off, so
  // turning the filter on later starts from the current input level.
  assign filtered = (filter == '0) ? synced : filt_q;
  // Saturating increment: the count sticks at all-ones instead of wrapping.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Synchroniser shift chain; bit 0 samples the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
    end
  end

  // Debounce: count cycles of disagreement, toggle the filtered bit on the
  // cycle the count reaches the filter value, restart on any agreement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (filter == '0) begin
      filt_q <= synced;
      cnt_q  <= '0;
    end else if (clear_cnt) begin
      cnt_q <= '0;
    end else if (synced == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_inc == filter) begin
      filt_q <= ~filt_q;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_inc;
    end
  end

endmodule

// File: rtl/pio_in_edge_ctrl.sv
// pio_in_edge_ctrl
// Avalon-MM parallel input port with per-channel synchroniser, debounce,
// configurable edge/level capture and a maskable level interrupt.
// Registers: 0 DATA (RO), 1 MODE (RW), 2 MASK (RW), 3 CAPTURE (W1C),
//            4 FILTER (RW), 5 RAW (RO), 6..7 read as 0.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   address          - word address
//   chipselect       - slave select
//   write_n          - active-low write strobe
//   writedata        - write data
//   in_port          - asynchronous external inputs
//   readdata         - registered read data (1-cycle latency, every cycle)
//   irq              - OR of CAPTURE AND MASK
module pio_in_edge_ctrl
  import pio_in_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("pio_in_edge_ctrl: WIDTH out of range");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("pio_in_edge_ctrl: SYNC_STAGES out of range");
  end

  logic [2*WIDTH-1:0] mode_q;
  logic [WIDTH-1:0]   mask_q;
  logic [WIDTH-1:0]   capture_q;
  logic [WIDTH-1:0]   prev_q;
  logic [CNT_W-1:0]   filter_q;
  logic [WIDTH-1:0]   synced;
  logic [WIDTH-1:0]   filtered;
  logic [WIDTH-1:0]   event_vec;
  logic [WIDTH-1:0]   clear_vec;
  logic [31:0]        rd_next;
  logic               wr_en;
  logic               filter_wr;
  logic               unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign filter_wr    = wr_en && (address == ADDR_FILTER);
  // Which writedata bits are stored depends on the parameters.
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pio_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_filter (
      .clk       (clk),
      .reset     (reset),
      .in_bit    (in_port[i]),
      .filter    (filter_q),
      .clear_cnt (filter_wr),
      .synced    (synced[i]),
      .filtered  (filtered[i])
    );
  end

  // Per-channel capture events and the write-1-to-clear mask.
  always_comb begin
    event_vec = '0;
    clear_vec = '0;
    if (wr_en && (address == ADDR_CAPTURE)) begin
      clear_vec = writedata[WIDTH-1:0];
    end
    for (int i = 0; i < WIDTH; i++) begin
      event_vec[i] = edge_event(edge_mode_e'(mode_q[2*i +: 2]), filtered[i], prev_q[i]);
    end
  end

  // Control registers. CAPTURE applies the clear first and the new events
  // last so an event arriving with a clear keeps the bit set. prev_q follows
  // the filtered value unconditionally, so MODE writes never fake an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= '0;
      mask_q    <= '0;
      capture_q <= '0;
      filter_q  <= '0;
      prev_q    <= '0;
    end else begin
      prev_q    <= filtered;
      capture_q <= (capture_q & ~clear_vec) | event_vec;
      if (wr_en) begin
        case (address)
          ADDR_MODE:   mode_q   <= writedata[2*WIDTH-1:0];
          ADDR_MASK:   mask_q   <= writedata[WIDTH-1:0];
          ADDR_FILTER: filter_q <= writedata[CNT_W-1:0];
          default:     ;
        endcase
      end
    end
  end

  // Read mux, sampled every cycle whatever chipselect is doing.
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next = 32'(filtered);
      ADDR_MODE:    rd_next = 32'(mode_q);
      ADDR_MASK:    rd_next = 32'(mask_q);
      ADDR_CAPTURE: rd_next = 32'(capture_q);
      ADDR_FILTER:  rd_next = 32'(filter_q);
      ADDR_RAW:     rd_next = 32'(synced);
      default:      rd_next = '0;
    endcase
  end

  // Registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = |(capture_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_ctrl.sv
// tb_pio_in_edge_ctrl
// Self-checking bench for pio_in_edge_ctrl: directed scenario tasks with
// hand-derived expectations, then a randomized run against a behavioural
// model of the register map, synchroniser delay and debounce rules.
module tb_pio_in_edge_ctrl;
  import pio_in_pkg::*;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;

  logic             clk        = 1'b0;
  logic             reset      = 1'b1;
  logic [2:0]       address    = '0;
  logic             chipselect = 1'b0;
  logic             write_n    = 1'b1;
  logic [31:0]      writedata  = '0;
  logic [WIDTH-1:0] in_port    = '0;
  wire  [31:0]      readdata;
  wire              irq;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pio_in_edge_ctrl #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    in_port = '0;
    wait_cycles(2);
    tests_run++;
    if (readdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      read_reg(3'(a), d);
      tests_run++;
      if (d !== 32'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset_reg%0d: got %h expected %h", a, d, 32'h0);
      end
    end
  endtask

  task automatic test_rising();
    logic [31:0] d;
    write_reg(ADDR_MASK, 32'h1);
    address = ADDR_CAPTURE;
    in_port[0] = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      tick();
      tests_run++;
      if (irq !== (k == SYNC_STAGES + 1)) begin
        tests_failed++;
        $display("[TB] FAIL rising_irq_cycle%0d: got %b expected %b", k, irq, (k == SYNC_STAGES + 1));
      end
    end
    tick();
    tests_run++;
    if (readdata !== 32'h1) begin
      tests_failed++;
      $display("[TB] FAIL rising_capture: got %h expected %h", readdata, 32'h1);
    end
    in_port[0] = 1'b0;
    wait_cycles(6);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("[TB] FAIL rising_ignores_fall: got %h expected %h", d, 32'h1);
    end
    write_reg(ADDR_CAPTURE, 32'hFF);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rising_clear: got cap %h irq %b expected 0 0", d, irq);
    end
    write_reg(ADDR_MASK, 32'h0);
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    logic [13:0] seen;
    write_reg(ADDR_FILTER, 32'h4);
    in_port[2] = 1'b1;
    wait_cycles(3);
    in_port[2] = 1'b0;
    wait_cycles(8);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL debounce_short_capture: got %h expected %h", d, 32'h0);
    end
    read_reg(ADDR_DATA, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL debounce_short_data: got %h expected %h", d, 32'h0);
    end
    // Six-cycle pulse: synced high after edges 2..7, filter toggles on the
    // 4th disagreeing edge (6) and back on edge 12; DATA reads lag by one.
    address = ADDR_DATA;
    in_port[2] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 7) in_port[2] = 1'b0;
      tick();
      seen[k-1] = readdata[2];
    end
    tests_run++;
    if (seen !== 14'h0FC0) begin
      tests_failed++;
      $display("[TB] FAIL debounce_long_data: got %b expected %b", seen, 14'h0FC0);
    end
    wait_cycles(4);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL debounce_long_capture: got %h expected %h", d, 32'h4);
    end
    write_reg(ADDR_FILTER, 32'h0);
    write_reg(ADDR_CAPTURE, 32'hFF);
  endtask

  task automatic test_fall_any();
    logic [31:0] d;
    write_reg(ADDR_MODE, 32'h4);
    in_port[1] = 1'b1;
    wait_cycles(6);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL fall_on_rise: got %h expected %h", d, 32'h0);
    end
    in_port[1] = 1'b0;
    wait_cycles(6);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h2) begin
      tests_failed++;
      $display("[TB] FAIL fall_on_fall: got %h expected %h", d, 32'h2);
    end
    write_reg(ADDR_CAPTURE, 32'hFF);
    write_reg(ADDR_MODE, 32'h8);
    in_port[1] = 1'b1;
    wait_cycles(6);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h2) begin
      tests_failed++;
      $display("[TB] FAIL any_on_rise: got %h expected %h", d, 32'h2);
    end
    write_reg(ADDR_CAPTURE, 32'h2);
    in_port[1] = 1'b0;
    wait_cycles(6);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h2) begin
      tests_failed++;
      $display("[TB] FAIL any_on_fall: got %h expected %h", d, 32'h2);
    end
    write_reg(ADDR_CAPTURE, 32'hFF);
    write_reg(ADDR_MODE, 32'h0);
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    in_port[3:0] = 4'hF;
    wait_cycles(6);
    in_port[3:0] = 4'h0;
    wait_cycles(6);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h0F) begin
      tests_failed++;
      $display("[TB] FAIL w1c_setup: got %h expected %h", d, 32'h0F);
    end
    write_reg(ADDR_CAPTURE, 32'hFFFF_FF05 & 32'h0000_0005);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h0A) begin
      tests_failed++;
      $display("[TB] FAIL w1c_partial: got %h expected %h", d, 32'h0A);
    end
    // The new rise on bit 1 lands in CAPTURE on the same edge as the clear.
    in_port[1] = 1'b1;
    repeat (SYNC_STAGES) tick();
    write_reg(ADDR_CAPTURE, 32'h2);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h0A) begin
      tests_failed++;
      $display("[TB] FAIL set_wins: got %h expected %h", d, 32'h0A);
    end
    write_reg(ADDR_CAPTURE, 32'h8);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h02) begin
      tests_failed++;
      $display("[TB] FAIL w1c_single: got %h expected %h", d, 32'h02);
    end
    in_port = '0;
    wait_cycles(4);
    write_reg(ADDR_CAPTURE, 32'hFF);
  endtask

  task automatic test_level();
    logic [31:0] d;
    write_reg(ADDR_MODE, 32'hC000);
    write_reg(ADDR_MASK, 32'h80);
    in_port[7] = 1'b1;
    wait_cycles(5);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL level_irq: got %b expected 1", irq);
    end
    write_reg(ADDR_CAPTURE, 32'h80);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL level_irq_after_clear: got %b expected 1", irq);
    end
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h80 || irq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL level_reset: got cap %h irq %b expected 80 1", d, irq);
    end
    write_reg(ADDR_MASK, 32'h0);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL level_masked: got %b expected 0", irq);
    end
    in_port[7] = 1'b0;
    wait_cycles(4);
    write_reg(ADDR_CAPTURE, 32'hFF);
    read_reg(ADDR_CAPTURE, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL level_release: got %h expected %h", d, 32'h0);
    end
    write_reg(ADDR_MODE, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] expv [0:5];
    logic [2:0]  addr_seq [0:5];
    in_port = 8'hFF;
    wait_cycles(6);
    write_reg(ADDR_MASK, 32'hFF);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_irq: got %b expected 1", irq);
    end
    write_reg(ADDR_FILTER, 32'd10);
    in_port = 8'h01;
    wait_cycles(4);
    reset = 1'b1;
    #1;
    tests_run++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got rd %h irq %b expected 0 0", readdata, irq);
    end
    wait_cycles(2);
    reset = 1'b0;
    // Bit 0 is still high: it resynchronises, rises, and is captured.
    addr_seq = '{ADDR_CAPTURE, ADDR_MODE, ADDR_MASK, ADDR_FILTER, ADDR_DATA, ADDR_CAPTURE};
    expv     = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h1};
    for (int k = 0; k < 6; k++) begin
      read_reg(addr_seq[k], d);
      tests_run++;
      if (d !== expv[k] || irq !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL post_reset_read%0d: got rd %h irq %b expected %h 0", k, d, irq, expv[k]);
      end
    end
    in_port = '0;
    wait_cycles(4);
    write_reg(ADDR_CAPTURE, 32'hFF);
  endtask

  // Behavioural model: inputs appear after SYNC_STAGES cycles; a filtered
  // bit follows its input once the input has disagreed for FILTER cycles in
  // a row; captures follow the mode rules on the filtered value.
  task automatic test_random();
    logic [WIDTH-1:0]   q[$];
    logic [WIDTH-1:0]   m_sync, m_freg, m_prev, m_cap, m_mask, m_fvis, ev, clr;
    logic [2*WIDTH-1:0] m_mode;
    logic [CNT_W-1:0]   m_filt;
    int                 streak [WIDTH];
    logic [31:0]        exp_rd;
    logic [1:0]         md;
    logic               wr, filt_wr, exp_irq;
    chipselect = 1'b0;
    write_n    = 1'b1;
    in_port    = '0;
    reset      = 1'b1;
    tick();
    reset = 1'b0;
    m_sync = '0; m_freg = '0; m_prev = '0; m_cap = '0; m_mask = '0;
    m_mode = '0; m_filt = '0;
    for (int i = 0; i < WIDTH; i++) streak[i] = 0;
    q = {};
    repeat (SYNC_STAGES - 1) q.push_back('0);
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < WIDTH; i++)
        if ($urandom_range(0, 3) == 0) in_port[i] = ~in_port[i];
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if (address == ADDR_FILTER) writedata[CNT_W-1:0] = CNT_W'($urandom_range(0, 5));
      wr      = chipselect && !write_n;
      filt_wr = wr && (address == ADDR_FILTER);
      m_fvis  = (m_filt == '0) ? m_sync : m_freg;
      case (address)
        ADDR_DATA:    exp_rd = 32'(m_fvis);
        ADDR_MODE:    exp_rd = 32'(m_mode);
        ADDR_MASK:    exp_rd = 32'(m_mask);
        ADDR_CAPTURE: exp_rd = 32'(m_cap);
        ADDR_FILTER:  exp_rd = 32'(m_filt);
        ADDR_RAW:     exp_rd = 32'(m_sync);
        default:      exp_rd = 32'h0;
      endcase
      for (int i = 0; i < WIDTH; i++) begin
        md = m_mode[2*i +: 2];
        if (md == 2'b00)      ev[i] = m_fvis[i] && !m_prev[i];
        else if (md == 2'b01) ev[i] = !m_fvis[i] && m_prev[i];
        else if (md == 2'b10) ev[i] = m_fvis[i] != m_prev[i];
        else                  ev[i] = m_fvis[i];
      end
      clr    = (wr && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;
      m_cap  = (m_cap & ~clr) | ev;
      m_prev = m_fvis;
      for (int i = 0; i < WIDTH; i++) begin
        if (m_filt == '0) begin
          m_freg[i] = m_sync[i];
          streak[i] = 0;
        end else if (filt_wr) begin
          streak[i] = 0;
        end else if (m_sync[i] != m_freg[i]) begin
          streak[i]++;
          if (streak[i] >= int'(m_filt)) begin
            m_freg[i] = ~m_freg[i];
            streak[i] = 0;
          end
        end else begin
          streak[i] = 0;
        end
      end
      if (wr && address == ADDR_MODE)   m_mode = writedata[2*WIDTH-1:0];
      if (wr && address == ADDR_MASK)   m_mask = writedata[WIDTH-1:0];
      if (filt_wr)                      m_filt = writedata[CNT_W-1:0];
      q.push_back(in_port);
      m_sync  = q.pop_front();
      exp_irq = |(m_cap & m_mask);
      tick();
      tests_run++;
      if (readdata !== exp_rd) begin
        tests_failed++;
        $display("[TB] FAIL rand_readdata c%0d a%0d: got %h expected %h", c, address, readdata, exp_rd);
      end
      tests_run++;
      if (irq !== exp_irq) begin
        tests_failed++;
        $display("[TB] FAIL rand_irq c%0d: got %b expected %b", c, irq, exp_irq);
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_rising();
    test_debounce();
    test_fall_any();
    test_w1c();
    test_level();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
